// File: rtl/bit_serial_add_sched_if.sv
// Request/grant/result bundle for the two-requester bit-serial adder scheduler.
interface bit_serial_add_sched_if #(
  parameter int WIDTH = 8
);
  logic             req0;
  logic [WIDTH-1:0] a0;
  logic [WIDTH-1:0] b0;
  logic             req1;
  logic [WIDTH-1:0] a1;
  logic [WIDTH-1:0] b1;
  logic             gnt0;
  logic             gnt1;
  logic             busy;
  logic             done;
  logic             owner;
  logic [WIDTH:0]   sum;

  modport master (
    output req0, a0, b0, req1, a1, b1,
    input  gnt0, gnt1, busy, done, owner, sum
  );

  modport slave (
    input  req0, a0, b0, req1, a1, b1,
    output gnt0, gnt1, busy, done, owner, sum
  );
endinterface

// File: rtl/bit_serial_add_sched.sv
// Two-requester round-robin scheduler sharing a single bit-serial full adder.
module bit_serial_add_sched #(
  parameter int WIDTH = 8
) (
  input logic                 clk,
  input logic                 rst,
  bit_serial_add_sched_if.slave bus
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] s_sr;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             prio;
  logic             any_req;
  logic             win;
  logic             s_bit;
  logic             c_next;

  // win=1 selects requester 1; prio=1 means requester 1 is favoured on a tie
  always_comb begin
    any_req = bus.req0 | bus.req1;
    win     = bus.req1 & (~bus.req0 | prio);
    s_bit   = a_sr[0] ^ b_sr[0] ^ carry;
    c_next  = (a_sr[0] & b_sr[0]) | (carry & (a_sr[0] ^ b_sr[0]));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      a_sr      <= '0;
      b_sr      <= '0;
      s_sr      <= '0;
      carry     <= 1'b0;
      cnt       <= '0;
      prio      <= 1'b0;
      bus.gnt0  <= 1'b0;
      bus.gnt1  <= 1'b0;
      bus.busy  <= 1'b0;
      bus.done  <= 1'b0;
      bus.owner <= 1'b0;
      bus.sum   <= '0;
    end else begin
      bus.gnt0 <= 1'b0;
      bus.gnt1 <= 1'b0;
      bus.done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (any_req) begin
            a_sr      <= win ? bus.a1 : bus.a0;
            b_sr      <= win ? bus.b1 : bus.b0;
            carry     <= 1'b0;
            cnt       <= '0;
            bus.owner <= win;
            prio      <= ~win;
            bus.gnt0  <= ~win;
            bus.gnt1  <= win;
            bus.busy  <= 1'b1;
            state     <= SHIFT;
          end
        end
        SHIFT: begin
          a_sr  <= a_sr >> 1;
          b_sr  <= b_sr >> 1;
          s_sr  <= {s_bit, s_sr[WIDTH-1:1]};
          carry <= c_next;
          cnt   <= cnt + CW'(1);
          if (cnt == LAST) state <= DONE;
        end
        DONE: begin
          // result and done are published together so partial sums never show
          bus.sum  <= {carry, s_sr};
          bus.done <= 1'b1;
          bus.busy <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_bit_serial_add_sched.sv
// Self-checking bench: directed scenarios plus random traffic against a timeline reference model.
module tb_bit_serial_add_sched;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  bit_serial_add_sched_if #(.WIDTH(W)) bus ();
  bit_serial_add_sched #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  // reference model: whole-operation view keyed on edge numbers
  int           edge_n  = 0;
  int           free_e  = 0;
  int           g_e     = 0;
  bit           pend    = 0;
  bit           prio_m  = 0;
  bit           p_owner = 0;
  logic [W:0]   p_sum   = '0;
  logic [W:0]   exp_sum = '0;
  bit           exp_owner, exp_busy, exp_done, exp_g0, exp_g1;
  int unsigned  m_grants = 0, m_dones = 0, o_grants = 0, o_dones = 0;
  int           gq_who[$];
  int           gq_edge[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
  endtask

  task automatic model_step();
    bit w;
    exp_g0 = 0; exp_g1 = 0; exp_done = 0;
    if (rst) begin
      pend = 0; exp_sum = '0; exp_owner = 0; prio_m = 0; free_e = edge_n + 1;
    end else begin
      if (pend && edge_n == g_e + W + 1) begin
        exp_done = 1; exp_sum = p_sum; pend = 0; m_dones++;
      end
      if (edge_n >= free_e && (bus.req0 || bus.req1)) begin
        w = bus.req0 && (!bus.req1 || !prio_m) ? 1'b0 : 1'b1;
        pend = 1; g_e = edge_n; p_owner = w; exp_owner = w; prio_m = !w;
        p_sum = w ? ({1'b0, bus.a1} + {1'b0, bus.b1}) : ({1'b0, bus.a0} + {1'b0, bus.b0});
        free_e = edge_n + W + 2;
        if (w) exp_g1 = 1; else exp_g0 = 1;
        m_grants++;
      end
    end
    exp_busy = pend && (edge_n <= g_e + W);
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check("gnt0", bus.gnt0, exp_g0);
    check("gnt1", bus.gnt1, exp_g1);
    check("busy", bus.busy, exp_busy);
    check("done", bus.done, exp_done);
    check("owner", bus.owner, exp_owner);
    check("sum", bus.sum, exp_sum);
    if (bus.gnt0 || bus.gnt1) begin
      o_grants++;
      gq_who.push_back(bus.gnt1 ? 1 : 0);
      gq_edge.push_back(edge_n);
    end
    if (bus.done) o_dones++;
    edge_n++;
  endtask

  task automatic run_op(input bit who, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] a_after, input logic [W:0] exp, input int abort_at);
    int k;
    bit seen;
    bus.req0 = !who; bus.req1 = who;
    if (who) begin bus.a1 = a; bus.b1 = b; end else begin bus.a0 = a; bus.b0 = b; end
    seen = 0; k = 0;
    while (!seen && k < 30) begin
      cyc();
      if (bus.gnt0 || bus.gnt1) seen = 1;
      k++;
    end
    check("grant_seen", seen, 1);
    check("grant_who", bus.gnt1, who);
    bus.req0 = 0; bus.req1 = 0;
    if (who) bus.a1 = a_after; else bus.a0 = a_after;
    seen = 0; k = 0;
    while (!seen && k < 30) begin
      if (abort_at != 0 && k == abort_at) begin
        rst = 1;
        cyc();
        rst = 0;
        check("abort_busy", bus.busy, 0);
        check("abort_done", bus.done, 0);
        check("abort_sum", bus.sum, 0);
        repeat (W + 4) cyc();
        return;
      end
      cyc();
      k++;
      if (bus.done) seen = 1;
    end
    check("done_seen", seen, 1);
    check("latency", k, W + 1);
    check("op_sum", bus.sum, exp);
    check("op_owner", bus.owner, who);
    cyc();
  endtask

  initial begin
    bus.req0 = 0; bus.req1 = 0;
    bus.a0 = '0; bus.b0 = '0; bus.a1 = '0; bus.b1 = '0;
    rst = 1;
    repeat (2) cyc();
    check("rst_sum", bus.sum, 0);
    check("rst_busy", bus.busy, 0);
    rst = 0;

    run_op(0, 8'hFF, 8'h01, 8'hFF, 9'h100, 0);
    run_op(1, 8'hAA, 8'h55, 8'hAA, 9'h0FF, 0);
    run_op(1, 8'h00, 8'h00, 8'h00, 9'h000, 0);
    run_op(0, 8'h0F, 8'h01, 8'hF0, 9'h010, 0);
    run_op(0, 8'h7F, 8'h01, 8'h7F, 9'h080, 4);
    run_op(0, 8'h7F, 8'h01, 8'h7F, 9'h080, 0);

    // contention right after reset, operands changing every cycle
    rst = 1; cyc(); rst = 0;
    gq_who.delete(); gq_edge.delete();
    bus.req0 = 1; bus.req1 = 1;
    repeat (4 * (W + 2) + 2) begin
      cyc();
      bus.a0 = W'($urandom); bus.b0 = W'($urandom);
      bus.a1 = W'($urandom); bus.b1 = W'($urandom);
    end
    bus.req0 = 0; bus.req1 = 0;
    check("cont_count", (gq_who.size() >= 4) ? 1 : 0, 1);
    if (gq_who.size() >= 4) begin
      for (int i = 0; i < 4; i++) check("cont_order", gq_who[i], i % 2);
      for (int i = 1; i < 4; i++) check("cont_period", gq_edge[i] - gq_edge[i-1], W + 2);
    end
    repeat (W + 3) cyc();

    // random traffic with occasional resets
    repeat (600) begin
      bus.req0 = ($urandom_range(0, 3) != 0);
      bus.req1 = ($urandom_range(0, 2) != 0);
      bus.a0 = W'($urandom); bus.b0 = W'($urandom);
      bus.a1 = W'($urandom); bus.b1 = W'($urandom);
      rst = ($urandom_range(0, 79) == 0);
      cyc();
    end
    rst = 0; bus.req0 = 0; bus.req1 = 0;
    repeat (W + 4) cyc();

    check("total_grants", o_grants, m_grants);
    check("total_dones", o_dones, m_dones);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/bit_serial_add_sched.md
BIT_SERIAL_ADD_SCHED -- requirements
Module: bit_serial_add_sched

Interface
REQ-001 The module SHALL have parameter WIDTH, default 8, the operand width in bits (legal range 2..32).
REQ-002 Port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-003 Port rst, input, 1: synchronous, active-high reset, sampled on the rising edge of clk.
REQ-004 Port req0, input, 1: requester 0 asks for an addition; held high until it is served.
REQ-005 Port a0, input, WIDTH: requester 0 operand A.
REQ-006 Port b0, input, WIDTH: requester 0 operand B.
REQ-007 Port req1, input, 1: requester 1 asks for an addition.
REQ-008 Port a1, input, WIDTH: requester 1 operand A.
REQ-009 Port b1, input, WIDTH: requester 1 operand B.
REQ-010 Port gnt0, output, 1: one-cycle pulse; requester 0 operands were captured.
REQ-011 Port gnt1, output, 1: one-cycle pulse; requester 1 operands were captured.
REQ-012 Port busy, output, 1: an operation is in progress (states SHIFT or DONE).
REQ-013 Port done, output, 1: one-cycle pulse; sum is valid for owner.
REQ-014 Port owner, output, 1: index of the requester served by the current or last operation.
REQ-015 Port sum, output, WIDTH+1: result A+B; the MSB is the final carry.

Function
REQ-016 The module SHALL contain exactly one bit-serial full adder: one sum bit per cycle, LSB first, with a 1-bit carry register.
REQ-017 The state machine SHALL have three states: IDLE, SHIFT and DONE.
REQ-018 In IDLE, if any reqN is high at a clock edge, the module SHALL do all of the following on that edge:
  - latch the winner's aN and bN into internal shift registers;
  - clear the carry and the bit counter;
  - set owner to the winner;
  - move to SHIFT;
  - pulse gntN high for the following cycle.
REQ-019 Arbitration SHALL be round-robin: after reset, requester 0 has priority; after serving requester X, the other requester has priority.
REQ-020 A lone requester SHALL always win, regardless of priority.
REQ-021 In SHIFT, each edge SHALL add operand bit i and the carry, store sum bit i, update the carry and increment the counter.
REQ-022 After the edge that processes bit WIDTH-1, the state SHALL move to DONE, with sum[WIDTH] equal to the final carry.
REQ-023 In DONE, done SHALL be high for exactly one cycle, and the next edge SHALL return the state to IDLE.
REQ-024 Latency: done SHALL be high exactly WIDTH+1 cycles after the gnt pulse cycle.
REQ-025 Throughput: a new grant SHALL be possible in the cycle after done, giving a period of WIDTH+2 cycles per operation.
REQ-026 sum and owner SHALL hold their last values until the next DONE; partial sums SHALL never be visible on sum.
REQ-027 Requests arriving while busy SHALL be ignored until IDLE; no queuing SHALL occur beyond the level of reqN.
REQ-028 If reqN drops or aN/bN change after the grant, the in-flight operation SHALL complete unchanged using the captured operands.
REQ-029 A requester still asserting req in the DONE cycle SHALL be treated as a new request; round-robin priority SHALL apply.
REQ-030 Overflow SHALL NOT occur: the WIDTH+1-bit sum covers the full range (max 2^(WIDTH+1)-2).

Reset
REQ-031 On rst=1 the module SHALL set:
  - state to IDLE;
  - carry, counter and shift registers to 0;
  - gnt0, gnt1, busy and done to 0;
  - sum to 0 and owner to 0;
  - round-robin priority to requester 0.
REQ-032 rst SHALL override all other inputs, including mid-SHIFT and in DONE.
REQ-033 An aborted operation SHALL produce no done pulse and no grant.
REQ-034 The first request after rst deasserts SHALL be granted on the first edge with rst=0.
REQ-035 Reset SHALL be synchronous only; no logic SHALL be sensitive to an rst edge.

Verification
REQ-036 The bench SHALL cover, with WIDTH=8:
  - Carry chain: req0, a0=0xFF, b0=0x01 -> gnt0 pulse; 9 cycles later done=1, owner=0, sum=0x100.
  - No-carry pattern: req1, a1=0xAA, b1=0x55 -> done with owner=1, sum=0x0FF. Next op 0x00+0x00 -> sum=0x000; carry from the previous op must not leak.
  - Contention after reset: req0 and req1 both high continuously -> grants alternate 0,1,0,1, one every 10 cycles; each sum matches its own captured operands.
  - Operand change after grant: a0 changes from 0x0F to 0xF0 the cycle after gnt0, with b0=0x01 -> sum=0x010.
  - Reset mid-operation: rst=1 at bit 4 of 0x7F+0x01 -> busy=0, done=0, sum=0, no done pulse; the re-issued request then returns sum=0x080.
REQ-037 The bench SHALL check every result against the reference a+b, and check that exactly one gnt pulse and one done pulse occur per operation.
